// File: rtl/bram_debug_loader.sv
// -----------------------------------------------------------------------------
// bram_debug_loader
//
// Loader/dumper for the RV32I core's debug BRAM ports. A host word stream
// issues commands that bulk-write the DataCache or InstCache, bulk-read one of
// them back out, or pulse the core reset. The core is held in reset whenever
// the loader touches memory.
//
// Ports
//   CPU_CLK, CPU_RST_N          clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op                      000 LOAD_D, 001 LOAD_I, 010 DUMP_D,
//                               011 DUMP_I, 100 RESET_CORE, others illegal
//   cmd_len                     word count for LOAD/DUMP (clamped to BRAM_WORDS)
//   in_valid/in_ready/in_data   load word stream
//   out_valid/out_ready/out_data dump word stream
//   dc_a2/dc_wd2/dc_we2/dc_rd2  DataCache debug port (1-cycle sync read)
//   ic_a2/ic_wd2/ic_we2/ic_rd2  InstCache debug port (1-cycle sync read)
//   core_rst                    active-high reset to the core
//   busy                        command in progress
//   done                        one-cycle pulse when a command completes
//   cmd_err                     one-cycle pulse when an illegal op is accepted
//
// Every output is a flop; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module bram_debug_loader #(
    parameter int BRAM_WORDS = 4096,
    parameter int LEN_W      = 13,
    parameter int RST_CYCLES = 5
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [31:0]      dc_a2,
    output logic [31:0]      dc_wd2,
    output logic [3:0]       dc_we2,
    input  logic [31:0]      dc_rd2,
    output logic [31:0]      ic_a2,
    output logic [31:0]      ic_wd2,
    output logic [3:0]       ic_we2,
    input  logic [31:0]      ic_rd2,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_DUMP_ADDR = 3'd2,
        ST_DUMP_WAIT = 3'd3,
        ST_DUMP_HOLD = 3'd4,
        ST_RST_CORE  = 3'd5
    } state_t;

    localparam logic [2:0] OP_LOAD_D     = 3'b000;
    localparam logic [2:0] OP_LOAD_I     = 3'b001;
    localparam logic [2:0] OP_DUMP_D     = 3'b010;
    localparam logic [2:0] OP_DUMP_I     = 3'b011;
    localparam logic [2:0] OP_RESET_CORE = 3'b100;

    localparam logic [31:0]      LAST_ADDR = 32'((BRAM_WORDS - 1) * 4);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(BRAM_WORDS);
    localparam logic [LEN_W-1:0] RST_LAST  = LEN_W'(RST_CYCLES - 1);

    // Control state
    state_t           state_q, state_d;
    logic             sel_i_q, sel_i_d;      // 1 = InstCache, 0 = DataCache
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;          // words done, or reset cycles done
    logic [31:0]      addr_q, addr_d;        // byte address of the next word

    // Registered outputs
    logic             cmd_ready_q, cmd_ready_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [31:0]      dc_a2_q, dc_a2_d;
    logic [31:0]      dc_wd2_q, dc_wd2_d;
    logic [3:0]       dc_we2_q, dc_we2_d;
    logic [31:0]      ic_a2_q, ic_a2_d;
    logic [31:0]      ic_wd2_q, ic_wd2_d;
    logic [3:0]       ic_we2_q, ic_we2_d;
    logic             core_rst_q, core_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cmd_err_q, cmd_err_d;

    logic [LEN_W-1:0] len_clamped;
    logic [LEN_W-1:0] cnt_inc;
    logic [31:0]      addr_inc;

    // Byte address of the following word, wrapping at the top of the cache.
    function automatic logic [31:0] next_addr(input logic [31:0] a);
        next_addr = (a >= LAST_ADDR) ? 32'd0 : a + 32'd4;
    endfunction

    always_comb begin
        len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
        cnt_inc     = cnt_q + LEN_W'(1);
        addr_inc    = next_addr(addr_q);
    end

    always_comb begin
        state_d    = state_q;
        sel_i_d    = sel_i_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        out_data_d = out_data_q;
        dc_a2_d    = dc_a2_q;
        dc_wd2_d   = dc_wd2_q;
        dc_we2_d   = 4'h0;
        ic_a2_d    = ic_a2_q;
        ic_wd2_d   = ic_wd2_q;
        ic_we2_d   = 4'h0;
        done_d     = 1'b0;
        cmd_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = 32'd0;
                    cnt_d  = '0;
                    len_d  = len_clamped;
                    case (cmd_op)
                        OP_LOAD_D, OP_LOAD_I: begin
                            sel_i_d = cmd_op[0];
                            if (len_clamped == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_LOAD;
                            end
                        end
                        OP_DUMP_D, OP_DUMP_I: begin
                            sel_i_d = cmd_op[0];
                            if (len_clamped == '0) begin
                                done_d = 1'b1;
                            end else begin
                                // First read address must be on the port
                                // during the DUMP_ADDR cycle.
                                state_d = ST_DUMP_ADDR;
                                if (cmd_op[0]) begin
                                    ic_a2_d = 32'd0;
                                end else begin
                                    dc_a2_d = 32'd0;
                                end
                            end
                        end
                        OP_RESET_CORE: begin
                            state_d = ST_RST_CORE;
                        end
                        default: begin
                            cmd_err_d = 1'b1;
                            done_d    = 1'b1;
                        end
                    endcase
                end
            end

            ST_LOAD: begin
                if (in_valid && in_ready_q) begin
                    if (sel_i_q) begin
                        ic_a2_d  = addr_q;
                        ic_wd2_d = in_data;
                        ic_we2_d = 4'hF;
                    end else begin
                        dc_a2_d  = addr_q;
                        dc_wd2_d = in_data;
                        dc_we2_d = 4'hF;
                    end
                    addr_d = addr_inc;
                    cnt_d  = cnt_inc;
                    // done is registered alongside the last write strobe.
                    if (cnt_inc == len_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DUMP_ADDR: begin
                state_d = ST_DUMP_WAIT;
            end

            ST_DUMP_WAIT: begin
                // rd2 now reflects the address driven in DUMP_ADDR.
                out_data_d = sel_i_q ? ic_rd2 : dc_rd2;
                state_d    = ST_DUMP_HOLD;
            end

            ST_DUMP_HOLD: begin
                if (out_ready) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DUMP_ADDR;
                        if (sel_i_q) begin
                            ic_a2_d = addr_inc;
                        end else begin
                            dc_a2_d = addr_inc;
                        end
                    end
                end
            end

            ST_RST_CORE: begin
                cnt_d = cnt_inc;
                if (cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_LOAD);
        out_valid_d = (state_d == ST_DUMP_HOLD);
        // Keep the core in reset through the final load write as well.
        core_rst_d  = (state_d != ST_IDLE) || (dc_we2_d != 4'h0) || (ic_we2_d != 4'h0);
    end

    always_ff @(posedge CPU_CLK) begin
        if (!CPU_RST_N) begin
            state_q     <= ST_IDLE;
            sel_i_q     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= 32'd0;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            dc_a2_q     <= 32'd0;
            dc_wd2_q    <= 32'd0;
            dc_we2_q    <= 4'h0;
            ic_a2_q     <= 32'd0;
            ic_wd2_q    <= 32'd0;
            ic_we2_q    <= 4'h0;
            core_rst_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_i_q     <= sel_i_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            dc_a2_q     <= dc_a2_d;
            dc_wd2_q    <= dc_wd2_d;
            dc_we2_q    <= dc_we2_d;
            ic_a2_q     <= ic_a2_d;
            ic_wd2_q    <= ic_wd2_d;
            ic_we2_q    <= ic_we2_d;
            core_rst_q  <= core_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign dc_a2     = dc_a2_q;
    assign dc_wd2    = dc_wd2_q;
    assign dc_we2    = dc_we2_q;
    assign ic_a2     = ic_a2_q;
    assign ic_wd2    = ic_wd2_q;
    assign ic_we2    = ic_we2_q;
    assign core_rst  = core_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_bram_debug_loader.sv
// -----------------------------------------------------------------------------
// tb_bram_debug_loader
//
// Directed bench for bram_debug_loader. Stimulus pushes the expected cache
// writes and dump words into queues; a negedge monitor pops and compares
// whenever the DUT presents a write strobe or a dump handshake. Two small
// BRAM models with 1-cycle synchronous read back the debug ports.
// -----------------------------------------------------------------------------
module tb_bram_debug_loader;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [12:0] cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] dc_a2, dc_wd2, dc_rd2;
    logic [3:0]  dc_we2;
    logic [31:0] ic_a2, ic_wd2, ic_rd2;
    logic [3:0]  ic_we2;
    logic        core_rst, busy, done, cmd_err;

    always #5 CPU_CLK = ~CPU_CLK;

    bram_debug_loader #(
        .BRAM_WORDS(4096),
        .LEN_W     (13),
        .RST_CYCLES(5)
    ) dut (
        .CPU_CLK  (CPU_CLK),
        .CPU_RST_N(CPU_RST_N),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .dc_a2    (dc_a2),
        .dc_wd2   (dc_wd2),
        .dc_we2   (dc_we2),
        .dc_rd2   (dc_rd2),
        .ic_a2    (ic_a2),
        .ic_wd2   (ic_wd2),
        .ic_we2   (ic_we2),
        .ic_rd2   (ic_rd2),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .cmd_err  (cmd_err)
    );

    // BRAM models
    logic [31:0] dc_mem [4096];
    logic [31:0] ic_mem [4096];
    always @(posedge CPU_CLK) begin
        if (dc_we2 == 4'hF) dc_mem[dc_a2[13:2]] <= dc_wd2;
        if (ic_we2 == 4'hF) ic_mem[ic_a2[13:2]] <= ic_wd2;
        dc_rd2 <= dc_mem[dc_a2[13:2]];
        ic_rd2 <= ic_mem[ic_a2[13:2]];
    end

    int cyc = 0;
    always @(posedge CPU_CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Scoreboard
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    wr_t         dc_exp[$];
    wr_t         ic_exp[$];
    logic [31:0] out_exp[$];

    int          done_cnt = 0;
    int          err_cnt = 0;
    int          dc_wr_cnt = 0;
    logic [31:0] last_dc_a2 = 32'd0;
    wr_t         mon_e;
    logic [31:0] mon_w;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_data = 32'd0;

    always @(negedge CPU_CLK) begin
        done_cnt = done_cnt + int'(done);
        err_cnt  = err_cnt + int'(cmd_err);
        if (dc_we2 != 4'h0) begin
            dc_wr_cnt++;
            last_dc_a2 = dc_a2;
            if (dc_exp.size() == 0) begin
                fail_now("dc_unexpected_write", $sformatf("got a2=%h wd2=%h, required no write", dc_a2, dc_wd2));
            end else begin
                mon_e = dc_exp.pop_front();
                check("dc_a2", dc_a2, mon_e.addr);
                check("dc_wd2", dc_wd2, mon_e.data);
                check("dc_we2", 32'(dc_we2), 32'hF);
                check("dc_a2_range", 32'(dc_a2 < 32'h4000), 32'd1);
                check("dc_done_with_write", 32'(done), 32'(mon_e.last));
                check("dc_core_rst", 32'(core_rst), 32'd1);
            end
        end
        if (ic_we2 != 4'h0) begin
            if (ic_exp.size() == 0) begin
                fail_now("ic_unexpected_write", $sformatf("got a2=%h wd2=%h, required no write", ic_a2, ic_wd2));
            end else begin
                mon_e = ic_exp.pop_front();
                check("ic_a2", ic_a2, mon_e.addr);
                check("ic_wd2", ic_wd2, mon_e.data);
                check("ic_we2", 32'(ic_we2), 32'hF);
                check("ic_done_with_write", 32'(done), 32'(mon_e.last));
                check("ic_core_rst", 32'(core_rst), 32'd1);
            end
        end
        if (out_valid) begin
            if (out_ready) begin
                if (out_exp.size() == 0) begin
                    fail_now("out_unexpected_word", $sformatf("got %h, required no word", out_data));
                end else begin
                    mon_w = out_exp.pop_front();
                    check("out_data", out_data, mon_w);
                    check("out_core_rst", 32'(core_rst), 32'd1);
                end
                hold_vld = 1'b0;
            end else begin
                if (hold_vld) check("out_data_stable", out_data, hold_data);
                hold_vld  = 1'b1;
                hold_data = out_data;
            end
        end else begin
            hold_vld = 1'b0;
        end
    end

    // Stimulus helpers: all called and returning at posedge + 1
    task automatic send_cmd(input logic [2:0] op, input logic [12:0] len);
        bit ok = 1'b0;
        cmd_op    = op;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CPU_CLK);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("cmd_accept_timeout", "cmd_ready stayed 0, required 1");
        @(posedge CPU_CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input bit gap_check);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge CPU_CLK);
            if (gap_check && i == 0) begin
                check("ic_we2_gap", 32'(ic_we2), 32'd0);
                check("core_rst_gap", 32'(core_rst), 32'd1);
            end
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("in_ready_timeout", "in_ready stayed 0, required 1");
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge CPU_CLK);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("idle_timeout", "busy stayed 1, required 0");
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic dump_word(input int stall);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CPU_CLK);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("out_valid_timeout", "out_valid stayed 0, required 1");
        repeat (stall + 1) @(posedge CPU_CLK);
        #1;
        out_ready = 1'b1;
        @(posedge CPU_CLK);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int w0;
        int c0;
        int k;
        int n;
        bit hs;

        CPU_RST_N = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_len   = 13'd0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;

        // Reset held 3 cycles
        repeat (3) @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dc_we2", 32'(dc_we2), 32'd0);
        check("rst_ic_we2", 32'(ic_we2), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_dc_a2", dc_a2, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge CPU_CLK);
        #1;
        CPU_RST_N = 1'b1;
        @(negedge CPU_CLK);
        check("core_rst_before_release", 32'(core_rst), 32'd1);
        @(posedge CPU_CLK);
        #1;
        @(negedge CPU_CLK);
        check("core_rst_first_idle", 32'(core_rst), 32'd0);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge CPU_CLK);
        #1;

        // LOAD_D len=4, back-to-back
        d0 = done_cnt;
        dc_exp.push_back('{addr: 32'h0, data: 32'h11111111, last: 1'b0});
        dc_exp.push_back('{addr: 32'h4, data: 32'h22222222, last: 1'b0});
        dc_exp.push_back('{addr: 32'h8, data: 32'h33333333, last: 1'b0});
        dc_exp.push_back('{addr: 32'hC, data: 32'h44444444, last: 1'b1});
        send_cmd(3'b000, 13'd4);
        check("load_d_busy", 32'(busy), 32'd1);
        c0 = cyc;
        push_word(32'h11111111, 1'b0);
        push_word(32'h22222222, 1'b0);
        push_word(32'h33333333, 1'b0);
        push_word(32'h44444444, 1'b0);
        check("load_d_cycles", 32'(cyc - c0), 32'd4);
        in_valid = 1'b0;
        wait_idle(20);
        check("load_d_done_count", 32'(done_cnt - d0), 32'd1);

        // LOAD_I len=3, in_valid every other cycle
        d0 = done_cnt;
        ic_exp.push_back('{addr: 32'h0, data: 32'hA0A0A0A0, last: 1'b0});
        ic_exp.push_back('{addr: 32'h4, data: 32'hB1B1B1B1, last: 1'b0});
        ic_exp.push_back('{addr: 32'h8, data: 32'hC2C2C2C2, last: 1'b1});
        send_cmd(3'b001, 13'd3);
        push_word(32'hA0A0A0A0, 1'b0);
        in_valid = 1'b0;
        @(posedge CPU_CLK);
        #1;
        push_word(32'hB1B1B1B1, 1'b1);
        in_valid = 1'b0;
        @(posedge CPU_CLK);
        #1;
        push_word(32'hC2C2C2C2, 1'b1);
        in_valid = 1'b0;
        wait_idle(20);
        check("load_i_done_count", 32'(done_cnt - d0), 32'd1);

        // DUMP_D len=4 with a stall on word 2
        d0 = done_cnt;
        out_exp.push_back(32'h11111111);
        out_exp.push_back(32'h22222222);
        out_exp.push_back(32'h33333333);
        out_exp.push_back(32'h44444444);
        send_cmd(3'b010, 13'd4);
        dump_word(0);
        dump_word(4);
        dump_word(0);
        dump_word(0);
        wait_idle(20);
        check("dump_d_done_count", 32'(done_cnt - d0), 32'd1);
        check("dump_d_all_words", 32'(out_exp.size()), 32'd0);

        // DUMP_I len=3 with out_ready held high
        d0 = done_cnt;
        out_exp.push_back(32'hA0A0A0A0);
        out_exp.push_back(32'hB1B1B1B1);
        out_exp.push_back(32'hC2C2C2C2);
        out_ready = 1'b1;
        send_cmd(3'b011, 13'd3);
        wait_idle(50);
        out_ready = 1'b0;
        check("dump_i_done_count", 32'(done_cnt - d0), 32'd1);
        check("dump_i_all_words", 32'(out_exp.size()), 32'd0);

        // LOAD_D len=5000 clamps to 4096 words
        d0 = done_cnt;
        w0 = dc_wr_cnt;
        for (int i = 0; i < 4096; i++) begin
            dc_exp.push_back('{addr: 32'(i * 4), data: 32'hD0000000 + 32'(i), last: (i == 4095)});
        end
        send_cmd(3'b000, 13'd5000);
        k = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            in_data = 32'hD0000000 + 32'(k);
            @(negedge CPU_CLK);
            hs = in_ready;
            @(posedge CPU_CLK);
            #1;
            if (hs) k++;
            else if (k > 0) break;
        end
        in_valid = 1'b0;
        wait_idle(20);
        check("clamp_handshakes", 32'(k), 32'd4096);
        check("clamp_writes", 32'(dc_wr_cnt - w0), 32'd4096);
        check("clamp_last_a2", last_dc_a2, 32'h3FFC);
        check("clamp_done_count", 32'(done_cnt - d0), 32'd1);

        // LOAD with len=0
        d0 = done_cnt;
        send_cmd(3'b000, 13'd0);
        @(negedge CPU_CLK);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_dc_we2", 32'(dc_we2), 32'd0);
        @(posedge CPU_CLK);
        #1;
        check("len0_done_count", 32'(done_cnt - d0), 32'd1);

        // RESET_CORE
        d0 = done_cnt;
        send_cmd(3'b100, 13'd0);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CPU_CLK);
            if (core_rst) n++;
            else break;
        end
        check("rst_core_cycles", 32'(n), 32'd5);
        check("rst_core_done_on_release", 32'(done), 32'd1);
        @(posedge CPU_CLK);
        #1;
        check("rst_core_done_count", 32'(done_cnt - d0), 32'd1);

        // Illegal op
        d0 = done_cnt;
        w0 = err_cnt;
        send_cmd(3'b111, 13'd3);
        @(negedge CPU_CLK);
        check("illegal_cmd_err", 32'(cmd_err), 32'd1);
        check("illegal_done", 32'(done), 32'd1);
        check("illegal_core_rst", 32'(core_rst), 32'd0);
        @(posedge CPU_CLK);
        #1;
        repeat (3) @(posedge CPU_CLK);
        #1;
        check("illegal_err_count", 32'(err_cnt - w0), 32'd1);
        check("illegal_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of LOAD_I
        ic_exp.push_back('{addr: 32'h0, data: 32'hE0E0E0E0, last: 1'b0});
        ic_exp.push_back('{addr: 32'h4, data: 32'hE1E1E1E1, last: 1'b0});
        send_cmd(3'b001, 13'd8);
        push_word(32'hE0E0E0E0, 1'b0);
        push_word(32'hE1E1E1E1, 1'b0);
        in_data   = 32'hE2E2E2E2;
        CPU_RST_N = 1'b0;
        @(negedge CPU_CLK);
        @(posedge CPU_CLK);
        @(negedge CPU_CLK);
        check("midrst_ic_we2", 32'(ic_we2), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_core_rst", 32'(core_rst), 32'd1);
        @(posedge CPU_CLK);
        #1;
        in_valid  = 1'b0;
        CPU_RST_N = 1'b1;
        @(posedge CPU_CLK);
        #1;
        @(negedge CPU_CLK);
        check("midrst_release_core_rst", 32'(core_rst), 32'd0);
        check("midrst_release_busy", 32'(busy), 32'd0);
        @(posedge CPU_CLK);
        #1;

        // Words written before the reset are intact
        d0 = done_cnt;
        out_exp.push_back(32'hE0E0E0E0);
        out_exp.push_back(32'hE1E1E1E1);
        out_ready = 1'b1;
        send_cmd(3'b011, 13'd2);
        wait_idle(50);
        out_ready = 1'b0;
        check("post_rst_dump_done_count", 32'(done_cnt - d0), 32'd1);

        repeat (3) @(posedge CPU_CLK);
        #1;
        check("dc_exp_drained", 32'(dc_exp.size()), 32'd0);
        check("ic_exp_drained", 32'(ic_exp.size()), 32'd0);
        check("out_exp_drained", 32'(out_exp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_debug_loader.md
Name: bram_debug_loader

Overview:
Synthesizable loader/dumper that drives the RV32I core's debug BRAM ports (DataCache/InstCache A2/WD2/WE2/RD2). It sits between a host word stream (e.g. a UART word assembler) and the core. It executes commands to bulk-write a cache, bulk-read a cache back out, and pulse the core reset. The core is held in reset whenever memory is being accessed.

Parameters:
BRAM_WORDS, 4096, words per cache; addresses wrap at BRAM_WORDS*4.
LEN_W, 13, width of cmd_len; must hold BRAM_WORDS.
RST_CYCLES, 5, CPU_CLK cycles core_rst is held high by a RESET_CORE command (minimum 1).

Ports:
CPU_CLK  in  1  clock
CPU_RST_N  in  1  synchronous reset, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  3  000 LOAD_D, 001 LOAD_I, 010 DUMP_D, 011 DUMP_I, 100 RESET_CORE, others illegal
cmd_len  in  LEN_W  word count for LOAD/DUMP
in_valid  in  1  load word valid
in_ready  out  1  load word ready
in_data  in  32  load word
out_valid  out  1  dump word valid
out_ready  in  1  dump word consumed
out_data  out  32  dump word
dc_a2  out  32  DataCache debug address (byte)
dc_wd2  out  32  DataCache debug write data
dc_we2  out  4  DataCache debug byte write enables
dc_rd2  in  32  DataCache debug read data, 1-cycle sync read
ic_a2, ic_wd2, ic_we2, ic_rd2  same as the dc_* ports, for InstCache
core_rst  out  1  active-high reset to the core (CPU_RST)
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
cmd_err  out  1  one-cycle pulse when an illegal op is accepted

Behaviour:
- Reset (CPU_RST_N=0 at a posedge):
  - All outputs go to 0, except cmd_ready=1 and core_rst=1. *_a2=0.
  - State goes to IDLE, discarding any command in flight. No partial write completes after reset.
- core_rst:
  - 1 in reset, LOAD, DUMP_* and RST_CORE states.
  - After reset it is released to 0 on the first IDLE cycle.
  - 0 in IDLE otherwise.
- IDLE: cmd_ready=1, busy=0. On cmd accept, latch op, len and target cache, clear the word address to 0, and set busy=1 the next cycle.
  - len clamp: any len above BRAM_WORDS is clamped to BRAM_WORDS.
  - len=0 on LOAD or DUMP: done pulses the next cycle; back to IDLE with no port activity.
  - Illegal op: cmd_err and done pulse together the next cycle; back to IDLE.
- LOAD: in_ready=1.
  - Each in handshake registers a2=addr, wd2=in_data, we2=4'b1111 on the selected cache for exactly one cycle, starting the cycle after the handshake.
  - The other cache's we2 stays 0. Then addr += 4.
  - No handshake in a cycle: we2=0 that cycle.
  - After the len-th word, in_ready drops the same cycle. done pulses in the cycle the last write is on the port, then IDLE.
  - Throughput is 1 word/cycle.
- DUMP, three states:
  - DUMP_ADDR: drive a2=addr, we2=0.
  - DUMP_WAIT: wait one cycle for the RD2 latency.
  - DUMP_HOLD: capture rd2 into out_data and set out_valid=1, holding out_data stable until out_ready.
  - On the out handshake: addr += 4. If words remain, go to DUMP_ADDR; otherwise pulse done and return to IDLE.
  - Maximum rate is 1 word per 3 cycles.
- Address wrap: addr wraps from (BRAM_WORDS-1)*4 to 0. It never drives an address at or above BRAM_WORDS*4.
- RESET_CORE: core_rst=1 for exactly RST_CYCLES cycles. done pulses on the first cycle core_rst returns to 0.
- cmd_valid while busy is ignored (cmd_ready=0). in_valid outside LOAD is ignored. out_valid=0 outside DUMP_HOLD.
- All outputs are registered. No combinational path from any input to any output.

Test Plan:
1. Reset held 3 cycles, then released -> cmd_ready=1, busy=0, all we2=0, core_rst=1 during reset and 0 on the first IDLE cycle.
2. LOAD_D len=4, data 0x11111111..0x44444444 streamed back-to-back -> dc_we2=4'hF on 4 consecutive cycles at dc_a2=0,4,8,C; ic_we2 stays 0; done pulses once with the 4th write.
3. LOAD_I len=3 with in_valid toggling every other cycle -> exactly 3 writes to ic at 0,4,8; ic_we2=0 on idle gaps; core_rst=1 throughout.
4. DUMP_D len=4 after test 2, out_ready low 5 cycles on word 2 -> out_data sequence 11111111, 22222222, 33333333, 44444444 with no loss or duplication; out_data stable while stalled.
5. LOAD_D len=5000 starting full -> clamped to 4096 writes; last dc_a2=0x3FFC; no address at or above 0x4000.
6. RESET_CORE with RST_CYCLES=5 -> core_rst high exactly 5 cycles, done on the release cycle. Op=111 -> cmd_err and done pulse, no port activity. CPU_RST_N low mid-LOAD -> we2=0 next cycle, return to IDLE.
